// File: rtl/chan_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : chan_arb_mux
// Description : N-channel registered stream mux with valid/ready handshakes,
//               explicit-select or round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 11,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        select,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [SELW-1:0] c_last_chan = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_last;

    logic             w_load_en;
    logic             w_fix_hit;
    logic [SELW-1:0]  w_fix_idx;
    logic             w_rr_hit;
    logic [SELW-1:0]  w_rr_idx;
    logic             w_gnt_valid;
    logic [SELW-1:0]  w_gnt_idx;
    logic [WIDTH-1:0] w_gnt_data;
    logic [NCH-1:0]   w_gnt_onehot;
    logic             w_xfer;

    assign w_load_en = !r_out_valid || out_ready;

    // A select outside 0..NCH-1 never matches any loop index, so it grants nothing.
    always_comb begin
        w_fix_hit = 1'b0;
        w_fix_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (select == SELW'(i) && in_valid[i]) begin
                w_fix_hit = 1'b1;
                w_fix_idx = SELW'(i);
            end
        end
    end

    // Rotating priority search starting just after the last round-robin winner.
    always_comb begin
        int v_idx;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        v_idx    = 0;
        for (int k = 1; k <= NCH; k++) begin
            v_idx = int'(r_rr_last) + k;
            if (v_idx >= NCH)
                v_idx = v_idx - NCH;
            if (!w_rr_hit && in_valid[v_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = SELW'(v_idx);
            end
        end
    end

    assign w_gnt_valid = mode ? w_rr_hit : w_fix_hit;
    assign w_gnt_idx   = mode ? w_rr_idx : w_fix_idx;

    always_comb begin
        w_gnt_data   = '0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data      = in_data[i*WIDTH +: WIDTH];
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    assign in_ready = (w_load_en && w_gnt_valid && !Reset) ? w_gnt_onehot : '0;
    assign w_xfer   = w_load_en && w_gnt_valid && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_last   <= c_last_chan;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_idx;
            if (mode)
                r_rr_last <= w_gnt_idx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_chan_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_chan_arb_mux
// Description : Directed self-checking bench for chan_arb_mux (NCH=11, WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_arb_mux;

    localparam int c_width = 32;
    localparam int c_nch   = 11;
    localparam int c_selw  = $clog2(c_nch);

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic [c_nch*c_width-1:0] in_data;
    logic [c_nch-1:0]         in_valid;
    logic [c_nch-1:0]         in_ready;
    logic                     mode;
    logic [c_selw-1:0]        select;
    logic [c_width-1:0]       out_data;
    logic [c_selw-1:0]        out_chan;
    logic                     out_valid;
    logic                     out_ready;

    int n_checks = 0;
    int n_errors = 0;

    chan_arb_mux #(.WIDTH(c_width), .NCH(c_nch)) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .select    (select),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int rr_seq[5] = '{2, 7, 9, 2, 7};

    initial begin
        Reset     = 1'b1;
        in_valid  = '0;
        mode      = 1'b0;
        select    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < c_nch; i++)
            in_data[i*c_width +: c_width] = 32'h100 + i;

        // Reset then idle
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_valid",    32'(out_valid), 32'h0);
        check("rst_data",     out_data, 32'h0);
        check("rst_chan",     32'(out_chan), 32'h0);
        Reset = 1'b0;
        tick();
        check("idle_valid",    32'(out_valid), 32'h0);
        check("idle_in_ready", 32'(in_ready), 32'h0);

        // Fixed select 5, all valid
        in_valid  = '1;
        select    = 4'd5;
        out_ready = 1'b1;
        #1;
        check("fix_in_ready5", 32'(in_ready), 32'h020);
        tick();
        check("fix_data5",  out_data, 32'h105);
        check("fix_chan5",  32'(out_chan), 32'd5);
        check("fix_valid5", 32'(out_valid), 32'd1);
        check("fix_full_rate_ready", 32'(in_ready), 32'h020);
        select = 4'd3;
        #1;
        check("fix_in_ready3", 32'(in_ready), 32'h008);
        tick();
        check("fix_data3", out_data, 32'h103);
        check("fix_chan3", 32'(out_chan), 32'd3);

        // Select beyond NCH grants nothing; held word drains
        select = 4'd12;
        #1;
        check("badsel_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("badsel_valid_a", 32'(out_valid), 32'h0);
        tick();
        check("badsel_valid_b", 32'(out_valid), 32'h0);

        // Round-robin over channels 2,7,9; pointer still at NCH-1
        mode     = 1'b1;
        in_valid = 11'b010_1000_0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_in_ready", 32'(in_ready), 32'h1 << rr_seq[k]);
            tick();
            check("rr_chan",  32'(out_chan), 32'(rr_seq[k]));
            check("rr_data",  out_data, 32'h100 + 32'(rr_seq[k]));
            check("rr_valid", 32'(out_valid), 32'd1);
        end

        // Back-pressure with channel 7 held
        out_ready = 1'b0;
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_chan",     32'(out_chan), 32'd7);
            check("bp_data",     out_data, 32'h107);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h200);
        tick();
        check("bp_release_chan",  32'(out_chan), 32'd9);
        check("bp_release_valid", 32'(out_valid), 32'd1);

        // Park pointer at 6, then reset mid-operation
        in_valid = 11'b000_0100_0000;
        tick();
        check("pre_rst_chan", 32'(out_chan), 32'd6);
        Reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data",  out_data, 32'h0);
        Reset    = 1'b0;
        in_valid = '1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h001);
        tick();
        check("post_rst_chan0", 32'(out_chan), 32'd0);
        check("post_rst_data0", out_data, 32'h100);
        tick();
        check("post_rst_chan1", 32'(out_chan), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chan_arb_mux.md
Name: chan_arb_mux

Overview:
- Parametrised N-channel registered stream multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: explicit select (generalises the existing combinational muxes) and round-robin arbitration.
- Used in the shortest-path datapath to funnel candidate node/distance words from several producer channels into a single consumer, one word per cycle, with back-pressure.

Parameters:
- WIDTH, 32, data bits per channel
- NCH, 11, number of input channels (2..16)
- SELW, $clog2(NCH), width of select and channel-index fields (derived; do not override)

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- in_data  input  NCH*WIDTH  packed channel words, channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready, at most one bit high
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  SELW  channel index used when mode = 0
- out_data  output  WIDTH  registered output word
- out_chan  output  SELW  index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (synchronous, while Reset = 1 at a Clk edge):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer rr_last = NCH-1, so the first search starts at channel 0.
  - in_ready = 0 while Reset is asserted.
  - Reset mid-transfer discards the held word; no partial state survives.
- Output stage: a single-entry register.
  - load_en = !out_valid | out_ready.
  - A new word may load in the same cycle the old one drains, giving full throughput of 1 word/cycle.
- Grant, combinational from current inputs and state:
  - mode = 0: grant channel `select` iff select < NCH and in_valid[select]. A select >= NCH grants nothing; there is no default channel.
  - mode = 1: grant the first i with in_valid[i], searching rr_last+1, rr_last+2, … modulo NCH. No valid channel means no grant.
- Handshakes:
  - in_ready[g] = load_en & grant valid; all other in_ready bits are 0.
  - Transfer on channel g occurs when in_valid[g] & in_ready[g].
- On a transfer at an edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - If mode = 1, rr_last <= g.
- Without a transfer:
  - If out_valid & out_ready, then out_valid <= 0; out_data and out_chan hold their last values.
  - rr_last changes only on a round-robin transfer; mode = 0 transfers leave it unchanged.
- Latency: input accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_chan stay stable and every in_ready bit is 0.
- Simultaneous drain and load: the old word is consumed and the new word is loaded at the same edge; out_valid stays 1.
- Mode or select changes:
  - Take effect for the grant in the same cycle.
  - Never corrupt a word already held in the output register.
- Wrap-around: with rr_last = NCH-1 the search begins at channel 0; with rr_last = 3 it begins at 4 and wraps through NCH-1 back to 0..3.
- Fairness: with all channels continuously valid and out_ready = 1, round-robin grants 0,1,…,NCH-1,0,… with no channel starved.
- Estimated size: roughly 150–250 lines of RTL (priority-rotate search, output register, handshake logic).

Test Plan:
- Reset then idle: Reset = 1 for 2 cycles, all in_valid = 0 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0; no change after release.
- Fixed mode, NCH = 11, mode = 0, select = 5:
  - in_valid = all ones, in_data[i] = 32'h100+i, out_ready = 1 → in_ready = 11'b000_0010_0000.
  - Next cycle: out_data = 32'h105, out_chan = 5, out_valid = 1, then one word per cycle.
- Invalid select: mode = 0, select = 12 (>= NCH), all channels valid → in_ready = 0 and out_valid stays 0.
- Round-robin ordering: mode = 1, channels 2, 7 and 9 valid continuously, out_ready = 1 → out_chan sequence 2,7,9,2,7,… at 1 word/cycle.
- Back-pressure: out_ready = 0 for 3 cycles with a word held.
  - out_data and out_chan stay unchanged and in_ready = 0 throughout.
  - When out_ready rises, the drain and the next load occur at the same edge with no bubble.
- Reset mid-operation: assert Reset while out_valid = 1 and rr_last = 6 → next cycle out_valid = 0; after release with all channels valid, the first round-robin grant is channel 0.
